emblem_sequencer: RTL and testbench

//  Frame-synchronous animation controller for the crest overlay generator. On a trigger
//  it sequences the emblem through wipe-in, hold, blink and wipe-out. It does this by

---
 rtl/overlay_pkg.sv | 41 ++++
 rtl/frame_timer.sv | 33 +++
 rtl/emblem_sequencer.sv | 177 +++++++++++++++++
 tb/tb_emblem_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/overlay_pkg.sv
// Shared definitions for the crest overlay path.
// Holds the animation state encoding, the emblem bounding box shared with the
// emblem generator, the animation timing constants and a saturating row
// advance used by both wipe directions.
package overlay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WIPE_IN  = 3'd1,
        ST_HOLD     = 3'd2,
        ST_BLINK    = 3'd3,
        ST_WIPE_OUT = 3'd4
    } seq_state_t;

    // Emblem bounding box (X1/Y1 are one past the last column/row).
    localparam logic [9:0] EMB_X0 = 10'd256;
    localparam logic [9:0] EMB_X1 = 10'd384;
    localparam logic [9:0] EMB_Y0 = 10'd144;
    localparam logic [9:0] EMB_Y1 = 10'd320;

    localparam logic [9:0] WIPE_STEP     = 10'd4;
    localparam int         HOLD_FRAMES   = 120;
    localparam int         BLINK_FRAMES  = 15;
    localparam int         BLINK_TOGGLES = 6;

    // Wide enough for the larger of the HOLD and BLINK reload values.
    localparam int TIMER_W = 7;

    localparam logic [5:0] RGB_BLACK = 6'b000000;

    // Advance a wipe line by step, computed at 11 bits and clamped to lim so
    // the 10-bit line never wraps.
    function automatic logic [9:0] wipe_advance(input logic [9:0] wy,
                                                input logic [9:0] step,
                                                input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, wy} + {1'b0, step};
        return (sum >= {1'b0, lim}) ? lim : sum[9:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter stepped once per frame.
// Ports:
//   clk, rst  - pixel clock, async active-high reset (count clears to 0)
//   load      - load load_val this clk (wins over dec)
//   load_val  - reload value
//   dec       - decrement this clk (held at 0 once reached)
//   cnt       - current count
//   zero      - cnt == 0
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/emblem_sequencer.sv
// Frame-synchronous animation controller for the crest overlay.
// On a trigger it runs the emblem through wipe-in, hold, blink and wipe-out by
// gating the generator's per-pixel draw/rgb; the gated pixel is registered.
// Ports:
//   clk, rst       - pixel clock, async active-high reset
//   frame_start    - 1-clk pulse on the first clk of vertical blank
//   trigger        - 1-clk pulse, start or extend the animation
//   x, y, active   - raster position and visible-area flag (x is not used)
//   emb_draw/rgb   - generator draw flag and colour for (x,y)
//   ovl_draw/rgb   - gated pixel, 1 clk after the inputs (rgb 0 when not drawn)
//   busy           - animation running (state != IDLE)
//   seq_state      - current state encoding
//
// Pulse semantics: trigger and frame_start are single-clk strobes with no
// back-pressure. A trigger is remembered in a pending flag until the next
// frame_start; a trigger coincident with frame_start counts for that frame.
// All state and counter changes happen only on frame_start clks, so the
// visible frame never tears.
module emblem_sequencer
    import overlay_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       trigger,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       emb_draw,
    input  logic [5:0] emb_rgb,
    output logic       ovl_draw,
    output logic [5:0] ovl_rgb,
    output logic       busy,
    output logic [2:0] seq_state
);

    localparam logic [TIMER_W-1:0] HOLD_LOAD  = TIMER_W'(HOLD_FRAMES - 1);
    localparam logic [TIMER_W-1:0] BLINK_LOAD = TIMER_W'(BLINK_FRAMES - 1);
    localparam logic [2:0]         LAST_TOG   = 3'(BLINK_TOGGLES - 1);

    seq_state_t         state;
    logic [9:0]         wipe_y;
    logic [2:0]         tog_cnt;
    logic               vis;
    logic               pend;
    logic               go;
    logic [9:0]         nxt_y;
    logic               t_load;
    logic [TIMER_W-1:0] t_val;
    logic               t_dec;
    logic [TIMER_W-1:0] frame_cnt;
    logic               t_zero;
    logic               show;
    logic               unused_x;

    assign unused_x = ^x;
    assign go       = pend | trigger;
    assign nxt_y    = wipe_advance(wipe_y, WIPE_STEP, EMB_Y1);

    // Timer control: the one counter serves HOLD and BLINK durations.
    always_comb begin
        t_load = 1'b0;
        t_val  = HOLD_LOAD;
        t_dec  = 1'b0;
        if (frame_start) begin
            case (state)
                ST_WIPE_IN: t_load = (nxt_y == EMB_Y1);
                ST_HOLD, ST_BLINK: begin
                    if (go) begin
                        t_load = 1'b1;
                    end else if (t_zero) begin
                        t_load = 1'b1;
                        t_val  = BLINK_LOAD;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    frame_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .cnt      (frame_cnt),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            wipe_y  <= EMB_Y0;
            tog_cnt <= '0;
            vis     <= 1'b1;
            pend    <= 1'b0;
        end else if (frame_start) begin
            pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state  <= ST_WIPE_IN;
                        wipe_y <= EMB_Y0;
                    end
                end
                ST_WIPE_IN: begin
                    wipe_y <= nxt_y;
                    if (nxt_y == EMB_Y1) state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!go && t_zero) begin
                        state   <= ST_BLINK;
                        tog_cnt <= '0;
                    end
                end
                ST_BLINK: begin
                    if (go) begin
                        state <= ST_HOLD;
                        vis   <= 1'b1;
                    end else if (t_zero) begin
                        if (tog_cnt == LAST_TOG) begin
                            state   <= ST_WIPE_OUT;
                            vis     <= 1'b1;
                            wipe_y  <= EMB_Y0;
                            tog_cnt <= '0;
                        end else begin
                            vis     <= ~vis;
                            tog_cnt <= tog_cnt + 1'b1;
                        end
                    end
                end
                ST_WIPE_OUT: begin
                    // A retrigger reverses the wipe from the current line.
                    wipe_y <= nxt_y;
                    if (go) begin
                        state <= ST_WIPE_IN;
                    end else if (nxt_y == EMB_Y1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end else if (trigger) begin
            pend <= 1'b1;
        end
    end

    // WIPE_IN/HOLD/BLINK reveal rows above the wipe line; WIPE_OUT keeps rows
    // at or below it.
    always_comb begin
        show = 1'b0;
        case (state)
            ST_WIPE_IN, ST_HOLD, ST_BLINK:
                show = active & emb_draw & vis & (y < wipe_y);
            ST_WIPE_OUT:
                show = active & emb_draw & (y >= wipe_y);
            default: show = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovl_draw <= 1'b0;
            ovl_rgb  <= RGB_BLACK;
        end else begin
            ovl_draw <= show;
            ovl_rgb  <= show ? emb_rgb : RGB_BLACK;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign seq_state = state;

endmodule

// File: tb/tb_emblem_sequencer.sv
module tb_emblem_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       trigger = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       active = 1'b0;
    logic       emb_draw = 1'b0;
    logic [5:0] emb_rgb = '0;
    logic       ovl_draw;
    logic [5:0] ovl_rgb;
    logic       busy;
    logic [2:0] seq_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic       active;
        logic       emb_draw;
        logic [9:0] y;
        logic [5:0] rgb;
        logic       exp_draw;
        logic [5:0] exp_rgb;
    } vec_t;

    vec_t vecs[8];

    emblem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .trigger     (trigger),
        .x           (x),
        .y           (y),
        .active      (active),
        .emb_draw    (emb_draw),
        .emb_rgb     (emb_rgb),
        .ovl_draw    (ovl_draw),
        .ovl_rgb     (ovl_rgb),
        .busy        (busy),
        .seq_state   (seq_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time limit reached, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change 1 time unit after the rising edge, and
    // outputs are sampled at that same point (they reflect the edge just taken).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    task automatic probe(input logic [9:0] py, output logic d);
        active   = 1'b1;
        emb_draw = 1'b1;
        emb_rgb  = 6'h2d;
        y        = py;
        step();
        d        = ovl_draw;
        active   = 1'b0;
        emb_draw = 1'b0;
    endtask

    initial begin
        logic d;
        logic [6:0] e;

        vecs[0] = '{1'b1, 1'b1, 10'd150, 6'b110110, 1'b1, 6'b110110};
        vecs[1] = '{1'b1, 1'b0, 10'd150, 6'b110110, 1'b0, 6'b000000};
        vecs[2] = '{1'b0, 1'b1, 10'd150, 6'b101010, 1'b0, 6'b000000};
        vecs[3] = '{1'b1, 1'b1, 10'd143, 6'b101010, 1'b1, 6'b101010};
        vecs[4] = '{1'b1, 1'b1, 10'd319, 6'b000111, 1'b1, 6'b000111};
        vecs[5] = '{1'b1, 1'b1, 10'd320, 6'b111111, 1'b0, 6'b000000};
        vecs[6] = '{1'b1, 1'b1, 10'd500, 6'b111111, 1'b0, 6'b000000};
        vecs[7] = '{1'b1, 1'b1, 10'd0,   6'b111111, 1'b1, 6'b111111};

        // Reset state
        step();
        step();
        check("reset_draw", ovl_draw, 0);
        check("reset_rgb", ovl_rgb, 0);
        check("reset_busy", busy, 0);
        check("reset_state", seq_state, 0);
        rst = 1'b0;
        step();

        // Mid-frame trigger waits for frame_start
        pulse_trigger();
        check("midframe_trig_state0", seq_state, 0);
        step();
        step();
        check("midframe_trig_state1", seq_state, 0);
        check("midframe_trig_busy", busy, 0);
        frame();
        check("trig_enter_wipe_in", seq_state, 1);
        probe(10'd143, d);
        check("wipe_in_first_row", d, 1);
        probe(10'd144, d);
        check("wipe_in_line_144", d, 0);

        // WIPE_IN: wipe_y = 144 + 4*(k-1), HOLD reached on frame 45
        for (int k = 2; k <= 45; k++) begin
            frame();
            check("wipe_in_state", seq_state, (k == 45) ? 2 : 1);
            probe(10'd200, d);
            check("wipe_in_y200", d, ((144 + 4 * (k - 1)) > 200) ? 1 : 0);
        end

        // HOLD pixel gate vectors, 1-clk latency
        for (int i = 0; i < 8; i++) begin
            active   = vecs[i].active;
            emb_draw = vecs[i].emb_draw;
            y        = vecs[i].y;
            emb_rgb  = vecs[i].rgb;
            exp_q.push_back({vecs[i].exp_draw, vecs[i].exp_rgb});
            step();
            e = exp_q.pop_front();
            check($sformatf("hold_vec%0d_draw", i), ovl_draw, e[6]);
            check($sformatf("hold_vec%0d_rgb", i), ovl_rgb, e[5:0]);
        end
        active   = 1'b0;
        emb_draw = 1'b0;
        step();
        check("hold_idle_pixel_rgb", ovl_rgb, 0);

        // HOLD lasts 120 frames
        frames(119);
        check("hold_before_blink", seq_state, 2);
        frame();
        check("hold_to_blink", seq_state, 3);

        // BLINK: toggle every 15 frames, WIPE_OUT after the 6th toggle
        for (int f = 1; f <= 90; f++) begin
            frame();
            check("blink_state", seq_state, (f == 90) ? 4 : 3);
            probe(10'd150, d);
            check("blink_vis", d, ((f / 15) % 2 == 0) ? 1 : 0);
        end

        // WIPE_OUT: wipe_y = 144 + 4*j, IDLE after 44 frames
        for (int j = 1; j <= 44; j++) begin
            frame();
            check("wipe_out_busy", busy, (j < 44) ? 1 : 0);
            probe(10'd200, d);
            check("wipe_out_y200", d, (j < 44 && 200 >= 144 + 4 * j) ? 1 : 0);
        end
        check("wipe_out_idle", seq_state, 0);

        // Trigger coincident with frame_start from IDLE
        trigger     = 1'b1;
        frame_start = 1'b1;
        step();
        trigger     = 1'b0;
        frame_start = 1'b0;
        check("same_clk_trigger_state", seq_state, 1);
        probe(10'd143, d);
        check("same_clk_row143", d, 1);
        probe(10'd144, d);
        check("same_clk_row144", d, 0);
        frames(44);
        check("second_hold", seq_state, 2);

        // Retrigger in HOLD reloads the hold count
        frames(60);
        pulse_trigger();
        frame();
        frames(119);
        check("hold_reload_still_hold", seq_state, 2);
        frame();
        check("hold_reload_blink", seq_state, 3);

        // Retrigger in BLINK returns to HOLD, visible
        frames(20);
        probe(10'd150, d);
        check("blink_hidden", d, 0);
        pulse_trigger();
        frame();
        check("blink_retrig_hold", seq_state, 2);
        probe(10'd150, d);
        check("blink_retrig_visible", d, 1);
        frames(119);
        check("third_hold_end", seq_state, 2);
        frame();
        frames(90);
        check("third_wipe_out", seq_state, 4);

        // Retrigger in WIPE_OUT at wipe_y=240 reverses from that line
        frames(24);
        probe(10'd239, d);
        check("wipe_out_240_row239", d, 0);
        probe(10'd240, d);
        check("wipe_out_240_row240", d, 1);
        pulse_trigger();
        check("wipe_out_pending_state", seq_state, 4);
        frame();
        check("reverse_state", seq_state, 1);
        probe(10'd243, d);
        check("reverse_row243", d, 1);
        probe(10'd244, d);
        check("reverse_row244", d, 0);
        frames(19);
        check("reverse_to_hold", seq_state, 2);

        // Async reset mid-HOLD while drawing
        active   = 1'b1;
        emb_draw = 1'b1;
        y        = 10'd150;
        emb_rgb  = 6'b110110;
        step();
        check("pre_reset_draw", ovl_draw, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_draw", ovl_draw, 0);
        check("async_reset_rgb", ovl_rgb, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_state", seq_state, 0);
        step();
        check("reset_held_draw", ovl_draw, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
